// File: rtl/bss_frame_sequencer_if.sv
// Byte-stream input and register-bank write bus of the frame sequencer.
// master drives the raw byte stream; slave is the sequencer itself.
interface bss_frame_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  data_out;
  logic [12:0] wr_strobe;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, data_out, wr_strobe, busy, frame_done, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, data_out, wr_strobe, busy, frame_done, frame_err
  );
endinterface

// File: rtl/bss_frame_sequencer.sv
// Decodes STX..ETX frames (ESC substitution, XOR checksum), buffers the 13-byte
// body, then replays it into the message register bank one strobe at a time.
module bss_frame_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 1,
  parameter int unsigned TIMEOUT    = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  bss_frame_sequencer_if.slave bus
);

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] ESC = 8'h1B;

  typedef enum logic [2:0] {
    S_IDLE, S_BODY, S_ESC, S_SETUP, S_STROBE, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  body_buf [0:13];
  logic [3:0]  idx;
  logic [7:0]  xsum;
  logic [3:0]  ri, ri_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] tcnt;
  logic        frame_err_q;

  logic        acc, in_frame, replaying, timeout_hit;
  logic        store, clr, err;
  logic [7:0]  dec;

  assign replaying   = (state == S_SETUP) || (state == S_STROBE);
  assign in_frame    = (state == S_BODY) || (state == S_ESC);
  assign acc         = bus.rx_valid && bus.rx_ready;
  assign timeout_hit = (TIMEOUT != 0) && in_frame && !acc && (tcnt == TIMEOUT);

  assign bus.rx_ready   = !replaying;
  assign bus.busy       = in_frame || replaying;
  assign bus.frame_done = (state == S_DONE);
  assign bus.frame_err  = frame_err_q;

  always_comb begin
    bus.data_out  = replaying ? body_buf[ri] : '0;
    bus.wr_strobe = (state == S_STROBE) ? (13'd1 << ri) : '0;
  end

  always_comb begin
    state_n = state;
    ri_n    = ri;
    cnt_n   = cnt;
    store   = 1'b0;
    clr     = 1'b0;
    err     = 1'b0;
    dec     = bus.rx_data;
    case (state)
      S_IDLE, S_DONE: begin
        // DONE already reopens the input, so a byte accepted there is handled as in IDLE.
        state_n = S_IDLE;
        if (acc && bus.rx_data == STX) begin
          state_n = S_BODY;
          clr     = 1'b1;
        end
      end
      S_BODY: begin
        if (timeout_hit) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end else if (acc) begin
          if (bus.rx_data == STX) begin
            err = 1'b1;
            clr = 1'b1;
          end else if (idx == 4'd14) begin
            // Only once body and checksum are in is 0x03 the terminator; before that it is data.
            err     = !(bus.rx_data == ETX && body_buf[13] == xsum);
            state_n = err ? S_IDLE : S_SETUP;
            ri_n    = '0;
            cnt_n   = '0;
          end else if (bus.rx_data == ACK || bus.rx_data == NAK) begin
            err     = 1'b1;
            state_n = S_IDLE;
          end else if (bus.rx_data == ESC) begin
            state_n = S_ESC;
          end else begin
            store = 1'b1;
          end
        end
      end
      S_ESC: begin
        if (timeout_hit) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end else if (acc) begin
          if (bus.rx_data == STX) begin
            err     = 1'b1;
            clr     = 1'b1;
            state_n = S_BODY;
          end else if (bus.rx_data inside {8'h82, 8'h83, 8'h86, 8'h95, 8'h9B}) begin
            dec     = bus.rx_data - 8'h80;
            store   = 1'b1;
            state_n = S_BODY;
          end else begin
            err     = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_CYC - 1) begin
          cnt_n   = '0;
          state_n = S_STROBE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_STROBE: begin
        if (cnt == STROBE_CYC - 1) begin
          cnt_n = '0;
          if (ri == 4'd12) begin
            state_n = S_DONE;
          end else begin
            ri_n    = ri + 4'd1;
            state_n = S_SETUP;
          end
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      xsum        <= '0;
      ri          <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_n;
      ri          <= ri_n;
      cnt         <= cnt_n;
      frame_err_q <= err;
      if (clr) begin
        idx  <= '0;
        xsum <= '0;
      end else if (store) begin
        idx <= idx + 4'd1;
        if (idx < 4'd13) xsum <= xsum ^ dec;
      end
      if (acc || !in_frame) tcnt <= '0;
      else                  tcnt <= tcnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (store) body_buf[idx] <= dec;
  end

endmodule

// File: tb/tb_bss_frame_sequencer.sv
// Scoreboard bench: expected strobe/data pairs are queued as frames are sent and
// compared against strobe events captured by a negedge monitor.
module tb_bss_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bss_frame_sequencer_if bus ();
  bss_frame_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q [$];
  logic [11:0] obs_q [$];
  logic [7:0]  tx_q  [$];
  logic [7:0]  exp_body [13];

  int cyc = 0, hs_cyc = 0, done_cyc = 0;
  int done_cnt = 0, err_cnt = 0, viol = 0, ready_low = 0;
  logic [12:0] prev_s = '0;
  logic [7:0]  prev_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_s = '0;
    end else begin
      if ($countones(bus.wr_strobe) > 1) viol++;
      if (bus.wr_strobe != 0 && bus.wr_strobe == prev_s && bus.data_out != prev_d) viol++;
      if (bus.wr_strobe != 0 && bus.wr_strobe != prev_s) begin
        if (bus.data_out != prev_d) viol++;
        for (int i = 0; i < 13; i++)
          if (bus.wr_strobe[i]) obs_q.push_back({4'(i), bus.data_out});
      end
      if (bus.frame_done) begin done_cnt++; done_cyc = cyc; end
      if (bus.frame_err) err_cnt++;
      if (!bus.rx_ready) ready_low++;
      prev_s = bus.wr_strobe;
      prev_d = bus.data_out;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic got;
    int n;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    do begin
      got = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 200);
    bus.rx_valid = 1'b0;
    hs_cyc = cyc;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL handshake byte %02h: rx_ready stayed %0b, required 1 within 200 cycles", b, got);
    end
  endtask

  task automatic send_tx();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic push_expected();
    for (int i = 0; i < 13; i++) exp_q.push_back({4'(i), exp_body[i]});
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s done_timeout: frame_done count %0d, required %0d", name, done_cnt, target);
    end
  endtask

  task automatic check_replay(input string name);
    logic [11:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s missing strobe: got none, required strobe %0d data %02h", name, e[11:8], e[7:0]);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s strobe: got strobe %0d data %02h, required strobe %0d data %02h",
                   name, o[11:8], o[7:0], e[11:8], e[7:0]);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra strobes: got %0d, required 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic load_f();
    tx_q = '{8'h02, 8'h88, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64, 8'hEB, 8'h03};
    exp_body = '{8'h88, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h05,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h64};
  endtask

  task automatic test_reset();
    checks++;
    if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset ctrl: rx_ready/busy/done/err %b%b%b%b, required 1000",
               bus.rx_ready, bus.busy, bus.frame_done, bus.frame_err);
    end
    checks++;
    if (bus.data_out !== 8'h00 || bus.wr_strobe !== 13'h0) begin
      errors++;
      $display("FAIL reset bus: data_out %02h wr_strobe %h, required 00 0000", bus.data_out, bus.wr_strobe);
    end
  endtask

  task automatic test_basic_frame();
    int e0 = err_cnt;
    load_f();
    push_expected();
    send_byte(tx_q.pop_front());
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic busy_after_stx: got %b, required 1", bus.busy);
    end
    send_tx();
    wait_done(done_cnt + 1, "basic");
    checks++;
    // frame_done occupies the 27th cycle after the ETX edge
    if (done_cyc - hs_cyc != 26) begin
      errors++;
      $display("FAIL basic done_latency: got %0d edges, required 26", done_cyc - hs_cyc);
    end
    check_replay("basic");
    checks++;
    if (err_cnt != e0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic after: err pulses %0d busy %b, required 0 0", err_cnt - e0, bus.busy);
    end
  endtask

  task automatic test_escape();
    load_f();
    tx_q = '{8'h02, 8'h88, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h05,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1B, 8'h82, 8'h8D, 8'h03};
    exp_body[12] = 8'h02;
    push_expected();
    send_tx();
    wait_done(done_cnt + 1, "escape");
    check_replay("escape");
  endtask

  task automatic test_bad_checksum();
    int e0 = err_cnt, d0 = done_cnt;
    load_f();
    tx_q[14] = 8'hEA;
    send_tx();
    checks++;
    if (bus.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL badsum err_at_etx: got %b, required 1", bus.frame_err);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || done_cnt != d0 || err_cnt != e0 + 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL badsum outcome: strobes %0d done %0d err %0d busy %b, required 0 0 1 0",
               obs_q.size(), done_cnt - d0, err_cnt - e0, bus.busy);
      obs_q.delete();
    end
  endtask

  task automatic test_restart();
    int e0 = err_cnt;
    tx_q = '{8'h02, 8'h88, 8'h00, 8'h01};
    send_tx();
    send_byte(8'h02);
    checks++;
    if (bus.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL restart err_at_stx: got %b, required 1", bus.frame_err);
    end
    load_f();
    void'(tx_q.pop_front());
    push_expected();
    send_tx();
    wait_done(done_cnt + 1, "restart");
    check_replay("restart");
    checks++;
    if (err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL restart err_pulses: got %0d, required 1", err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    ready_low = 0;
    load_f();
    push_expected();
    push_expected();
    for (int k = 0; k < 16; k++) tx_q.push_back(tx_q[k]);
    send_tx();
    wait_done(d0 + 2, "b2b");
    check_replay("b2b");
    checks++;
    if (ready_low != 52) begin
      errors++;
      $display("FAIL b2b ready_low_cycles: got %0d, required 52", ready_low);
    end
  endtask

  task automatic test_reset_mid_replay();
    int n = 0;
    load_f();
    send_tx();
    while (bus.wr_strobe[5] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bus.wr_strobe[5] !== 1'b1) begin
      errors++;
      $display("FAIL midrst strobe5: got %b, required 1", bus.wr_strobe[5]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.wr_strobe !== 13'h0 || bus.data_out !== 8'h00 || bus.busy !== 1'b0 ||
        bus.rx_ready !== 1'b1 || bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst outputs: strobe %h data %02h busy %b ready %b, required 0000 00 0 1",
               bus.wr_strobe, bus.data_out, bus.busy, bus.rx_ready);
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_f();
    push_expected();
    send_tx();
    wait_done(done_cnt + 1, "midrst");
    check_replay("midrst");
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_frame();
    test_escape();
    test_bad_checksum();
    test_restart();
    test_back_to_back();
    test_reset_mid_replay();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_invariants: got %0d violations, required 0", viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
